// File: rtl/vending_pkg.sv
// Shared vending definitions: FSM state encodings (also the State_out convention)
// and coin values expressed in nickels.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DISP_DIME   = 3'd1,
        ST_DISP_NICKEL = 3'd2,
        ST_DONE        = 3'd3,
        ST_FAULT       = 3'd4
    } pay_state_e;

    localparam int NICKEL_VAL = 1;
    localparam int DIME_VAL   = 2;

endpackage

// File: rtl/payout_watchdog.sv
// Ack watchdog for the coin payout FSM: counts DISP cycles without an Ack and
// flags expiry on the cycle the count would reach TIMEOUT.
module payout_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Combinational so the FSM can leave DISP on the very cycle the limit is hit.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vending_coin_payout.sv
// Coin-payout transmitter: pays Amount nickels as dimes first, then at most one
// nickel, one Ack per coin. Optional Ack watchdog under PAYOUT_TIMEOUT_EN.
module vending_coin_payout
    import vending_pkg::*;
#(
    parameter int AMT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic [AMT_W-1:0] Amount,
    input  logic             Ack,
    output logic             Nickel,
    output logic             Dime,
    output logic             Busy,
    output logic             Done,
    output logic             Fault,
    output logic [2:0]       State_out
);

    localparam logic [AMT_W-1:0] DIME_N   = AMT_W'(DIME_VAL);
    localparam logic [AMT_W-1:0] NICKEL_N = AMT_W'(NICKEL_VAL);

    pay_state_e       state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] rem_after_dime;
    logic             in_disp;
    logic             wdog_expired;

    assign rem_after_dime = rem_q - DIME_N;
    assign in_disp        = (state_q == ST_DISP_DIME) || (state_q == ST_DISP_NICKEL);

`ifdef PAYOUT_TIMEOUT_EN
    logic fault_q;

    payout_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (!in_disp || Ack),
        .en_i      (in_disp && !Ack),
        .expired_o (wdog_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fault_q <= 1'b0;
        else
            fault_q <= (state_d == ST_FAULT);
    end

    assign Fault = fault_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT ^ in_disp;
    assign wdog_expired   = 1'b0;
    assign Fault          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    rem_d = Amount;
                    if (Amount == '0)
                        state_d = ST_DONE;
                    else if (Amount >= DIME_N)
                        state_d = ST_DISP_DIME;
                    else
                        state_d = ST_DISP_NICKEL;
                end
            end
            ST_DISP_DIME: begin
                if (Ack) begin
                    rem_d = rem_after_dime;
                    if (rem_after_dime >= DIME_N)
                        state_d = ST_DISP_DIME;
                    else if (rem_after_dime == NICKEL_N)
                        state_d = ST_DISP_NICKEL;
                    else
                        state_d = ST_DONE;
                end else if (wdog_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DISP_NICKEL: begin
                if (Ack) begin
                    rem_d   = '0;
                    state_d = ST_DONE;
                end else if (wdog_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;   // only reset leaves FAULT
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            Dime      <= 1'b0;
            Nickel    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            State_out <= 3'd0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            Dime      <= (state_d == ST_DISP_DIME);
            Nickel    <= (state_d == ST_DISP_NICKEL);
            Busy      <= (state_d != ST_IDLE);
            Done      <= (state_d == ST_DONE);
            State_out <= state_d;
        end
    end

endmodule

// File: doc/vending_coin_payout.md
# vending_coin_payout

Coin-payout transmitter for the vending subsystem: the sending end of the Nickel/Dime coin interface. Given a change amount in 5-cent units, it drives one coin at a time toward the dispenser mechanism, dimes first and then at most one nickel, waiting for a mechanism acknowledge per coin. It sits between the vending controller's change computation and the coin-hopper driver, and is a Moore machine in the same style as the coin-accepting vending FSM.

## Interface
- `AMT_W`, default 4: width of `Amount` in nickels; the maximum request is (2^AMT_W − 1) × 5 cents.
- `TIMEOUT`, default 15: number of cycles to wait for `Ack` before faulting (used only with the timeout feature).
- `clk` input, 1 bit: the single clock; everything is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state.
- `Req` input, 1 bit: payout request, sampled only in IDLE.
- `Amount` input, AMT_W bits: change owed in nickels, latched when `Req` is accepted.
- `Ack` input, 1 bit: the mechanism has dropped the currently presented coin.
- `Nickel` output, 1 bit: present a nickel (Moore; high throughout DISP_NICKEL).
- `Dime` output, 1 bit: present a dime (Moore; high throughout DISP_DIME).
- `Busy` output, 1 bit: high whenever the state is not IDLE.
- `Done` output, 1 bit: one-cycle pulse when the payout completes.
- `Fault` output, 1 bit: sticky high in FAULT; tied to 0 when the timeout feature is compiled out.
- `State_out` output, 3 bits: current state encoding, for debug and LEDs.

## Operation
- States and encodings: IDLE=0, DISP_DIME=1, DISP_NICKEL=2, DONE=3, FAULT=4.
- Register `rem`, AMT_W bits, holds the nickels still owed.
- IDLE, with `Req`=1:
  - `rem` ← `Amount`.
  - Next state is DONE if `Amount`=0, else DISP_DIME if `Amount`≥2, else DISP_NICKEL.
- IDLE, with `Req`=0: stay in IDLE.
- DISP_DIME, with `Ack`=1:
  - `rem` ← `rem`−2.
  - Next state is DISP_DIME if the new `rem`≥2, DISP_NICKEL if it is 1, DONE if it is 0.
- DISP_NICKEL, with `Ack`=1: `rem` ← 0, next state DONE.
- In either DISP state with `Ack`=0: hold the state and keep presenting the same coin.
- DONE: `Done`=1 for exactly that cycle; next state IDLE unconditionally.
- Ordering is fixed: all dimes before the nickel. The coin count is floor(Amount/2) dimes plus Amount mod 2 nickels.
- `Req` is ignored while `Busy`; `Amount` changes after acceptance have no effect.
- `Ack` is ignored in IDLE, DONE and FAULT.
- `Nickel` and `Dime` are never high together. Both are low in IDLE, DONE and FAULT.
- Arithmetic is unsigned; `rem` never underflows because the decrement happens only when `rem`≥2 (dime) or `rem`=1 (nickel).

## Timing
- Reset values: state=IDLE, `rem`=0, and `Nickel`=`Dime`=`Busy`=`Done`=`Fault`=0, `State_out`=0. Reset takes effect immediately, without waiting for a clock edge.
- Reset during a payout aborts it. Unpaid coins are lost, nothing resumes, and the next `Req` starts fresh.
- Latency: `Req` sampled at edge k puts the first coin output high after edge k. `Done` rises one edge after the final `Ack`.
- An `Ack` high on the same cycle a DISP state is entered counts. A level-held `Ack` therefore pays one coin per cycle.
- Full 15-cent change (`Amount`=3) with `Ack` held high: DISP_DIME → DISP_NICKEL → DONE → IDLE, taking 4 cycles in total from `Req` acceptance.
- The earliest a new `Req` can be accepted is the cycle after DONE.

## Configuration
- Macro `PAYOUT_TIMEOUT_EN`. When defined:
  - A watchdog counter clears on entry to each DISP state and on every accepted `Ack`, and increments on other DISP cycles.
  - If it reaches `TIMEOUT`, the next state is FAULT, with `Fault`=1 and both coin outputs at 0.
  - FAULT is left only by `reset`.
- When undefined:
  - DISP states wait indefinitely for `Ack`.
  - The FAULT state is unreachable, the counter logic is absent, and `Fault` is driven 0.

## Structure
- Shared package `vending_pkg`:
  - State typedef and encodings (shared with the vending FSM's `State_out` convention).
  - Coin value constants `NICKEL_VAL`=1 and `DIME_VAL`=2, in nickels.
- One sub-module, `payout_watchdog`: the timeout counter, with clear/enable inputs and an expired output. It is instantiated only under `PAYOUT_TIMEOUT_EN`.
- The FSM, `rem` datapath and output decode stay in the top module.

## Test plan
- Reset, then `Req`=1 with `Amount`=3 and `Ack` held at 1 → `Dime` for 1 cycle, then `Nickel` for 1 cycle, then a `Done` pulse; `Busy` is high for exactly 3 cycles.
- `Amount`=4 with `Ack` delayed 2 cycles per coin → `Dime` high for 3 cycles, twice, and never `Nickel`; `Done` follows the second `Ack`.
- `Amount`=0 → no coin outputs; `Done` on the cycle after `Req`, then IDLE.
- New `Req` with `Amount`=1 while paying `Amount`=5 → the extra request is ignored: exactly 2 dimes plus 1 nickel are paid, with no extra nickel.
- Assert `reset` asynchronously mid-DISP_DIME (not on a clock edge) → all outputs go to 0 immediately and `State_out`=0; a subsequent `Amount`=1 pays a single nickel.
- With `PAYOUT_TIMEOUT_EN` and `TIMEOUT`=15: `Amount`=2 and `Ack` never asserted → `Dime` high for 15 cycles, then `Fault`=1 and `Dime`=0, sticky until reset. Without the macro, `Dime` stays high and `Fault` stays 0.
